tl_burst_rr_arbiter: RTL and testbench
======================================

// Module: tl_burst_rr_arbiter
// PURPOSE
//  Shares one TL A-type channel (A or C payload) between NumReq requesters.
//  Round-robin, burst-aware: once a multi-beat message wins, the grant is held until its last beat.
//  Zero-latency combinational datapath; only the grant/lock state is registered.
//  Sits in front of tl_ram_terminator/tl adapters wherever several agents merge onto one link.
// PARAMETERS
//  NumReq       2   number of requesters (>=2)
//  DataWidth    64  beat width in bits; NonBurstSize = $clog2(DataWidth/8)
//  PayloadWidth 128 width of opaque forwarded message payload
//  MaxSize      6   largest legal log2 message size in bytes
// PORTS
//  clk_i           in   1                   clock
//  rst_ni          in   1                   async active-low reset
//  req_valid_i     in   NumReq              per-requester valid
//  req_ready_o     out  NumReq              per-requester ready
//  req_size_i      in   NumReq*4            per-requester log2 size (TL size field)
//  req_has_data_i  in   NumReq              message carries data (PutFull/PutPartial/ProbeAckData/ReleaseData)
//  req_payload_i   in   NumReq*PayloadWidth per-requester payload
//  dev_valid_o     out  1                   merged valid
//  dev_ready_i     in   1                   merged ready
//  dev_payload_o   out  PayloadWidth        selected payload
//  dev_idx_o       out  $clog2(NumReq)      index of selected requester (for source tagging)
//  dev_last_o      out  1                   current beat is last of its message
// BEHAVIOUR
//  beats(size,has_data) = (has_data && size > NonBurstSize) ? 2**(size-NonBurstSize) : 1.
//  Beat counter width $clog2(2**(MaxSize-NonBurstSize))+1; it counts remaining beats.
//  States:
//   IDLE  - sel = RR winner among req_valid_i; priority starts at ptr_q, wraps NumReq-1 -> 0.
//   HOLD  - offered but not accepted; sel frozen to sel_q (valid must not be withdrawn).
//   BURST - sel frozen to sel_q until the last beat is accepted.
//  Transitions:
//   IDLE, any valid, !dev_ready_i -> HOLD (sel_q <= winner).
//   IDLE/HOLD, handshake, beats==1 -> IDLE, ptr_q <= sel+1 (mod NumReq).
//   IDLE/HOLD, handshake, beats>1 -> BURST, cnt_q <= beats-1.
//   BURST, handshake -> cnt_q--; when cnt_q==1 -> IDLE, ptr_q <= sel_q+1.
//   BURST, no handshake -> stay; cnt_q unchanged.
//  dev_valid_o = req_valid_i[sel]; dev_payload_o = req_payload_i[sel]; dev_idx_o = sel.
//  req_ready_o[i] = dev_ready_i && (sel==i) && state allows; all others 0.
//  dev_last_o = (state!=BURST) ? beats(sel)==1 : cnt_q==1.
//  In IDLE with no valid: dev_valid_o=0, dev_idx_o=ptr_q, dev_last_o=1.
//  A requester that drops valid mid-burst stalls the link; it is not skipped (TL forbids the drop).
//  Simultaneous requests: winner is the first valid at or after ptr_q; ptr_q moves only at message end.
//  Requesters that are not granted see ready=0 and keep their valid and payload stable.
//  size > MaxSize is illegal; an assertion fires and beats are clamped to the MaxSize count.
//  Reset (asynchronous, any cycle, including mid-burst): state=IDLE, ptr_q=0, sel_q=0, cnt_q=0.
//   Outputs follow combinationally: ready=0 and valid=0 unless an input valid is already high.
//  Single-beat messages never enter BURST; they add no latency and give full throughput.
// TESTING
//  1. NumReq=2; both valid with single-beat Get repeatedly, dev_ready=1 -> grants 0,1,0,1..., dev_last_o=1 each beat.
//  2. Req0 PutFull size=6 (8 beats @64b) + req1 Get -> 8 consecutive req0 beats, last on beat 8, then req1.
//  3. Req1 valid, dev_ready=0 for 3 cycles, req0 raises valid in cycle 2 -> dev_idx_o stays 1 until accepted.
//  4. Burst with dev_ready toggling 1010... -> cnt_q decrements only on handshakes; exactly 8 beats forwarded.
//  5. Assert rst_ni low at beat 3 of a 4-beat burst -> state IDLE, ptr_q=0; next arbitration starts at req0.
//  6. Req with has_data=0, size=6 (AcquireBlock/Get) -> single beat, no lock, ptr_q advances immediately.

Source files
------------

// File: rtl/tl_burst_rr_arbiter.sv
// ============================================================================
// tl_burst_rr_arbiter : round-robin TL A/C channel merger with burst lock
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tl_burst_rr_arbiter #(
  parameter int NumReq       = 2,
  parameter int DataWidth    = 64,
  parameter int PayloadWidth = 128,
  parameter int MaxSize      = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*4-1:0]            req_size_i,
  input  logic [NumReq-1:0]              req_has_data_i,
  input  logic [NumReq*PayloadWidth-1:0] req_payload_i,
  output logic                           dev_valid_o,
  input  logic                           dev_ready_i,
  output logic [PayloadWidth-1:0]        dev_payload_o,
  output logic [$clog2(NumReq)-1:0]      dev_idx_o,
  output logic                           dev_last_o
);

  localparam int NonBurstSize = $clog2(DataWidth/8);
  localparam int CntW         = $clog2(2**(MaxSize-NonBurstSize)) + 1;
  localparam int IdxW         = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   sel;
  logic              any_valid;
  logic              grant_ok;
  logic              handshake;
  logic [CntW-1:0]   sel_beats;

  logic [PayloadWidth-1:0] payload_arr [NumReq];
  logic [CntW-1:0]         beats_arr   [NumReq];

  // Illegal sizes are clamped so a bad master cannot overrun the counter.
  function automatic logic [CntW-1:0] beats_f(input logic [3:0] size, input logic has_data);
    logic [3:0] s;
    s = (size > 4'(MaxSize)) ? 4'(MaxSize) : size;
    if (has_data && (s > 4'(NonBurstSize))) begin
      beats_f = CntW'(1) << (s - 4'(NonBurstSize));
    end else begin
      beats_f = CntW'(1);
    end
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    next_idx = (idx == IdxW'(NumReq-1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign payload_arr[i] = req_payload_i[i*PayloadWidth +: PayloadWidth];
    assign beats_arr[i]   = beats_f(req_size_i[i*4 +: 4], req_has_data_i[i]);
  end

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    int idx;
    logic found;
    winner = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(ptr_q) + k) % NumReq;
      if (!found && req_valid_i[idx]) begin
        winner = IdxW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid_i;
  assign sel       = (state_q == IDLE) ? winner : sel_q;
  assign grant_ok  = (state_q != IDLE) || any_valid;
  assign sel_beats = beats_arr[sel];

  assign dev_valid_o   = req_valid_i[sel];
  assign dev_payload_o = payload_arr[sel];
  assign dev_idx_o     = sel;
  assign handshake     = dev_valid_o && dev_ready_i;

  always_comb begin
    dev_last_o = 1'b1;
    if (state_q == BURST) begin
      dev_last_o = (cnt_q == CntW'(1));
    end else if (grant_ok) begin
      dev_last_o = (sel_beats == CntW'(1));
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (dev_ready_i && grant_ok) begin
      req_ready_o[sel] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HOLD: begin
        if (handshake) begin
          if (sel_beats == CntW'(1)) begin
            state_d = IDLE;
            ptr_d   = next_idx(sel);
          end else begin
            state_d = BURST;
            sel_d   = sel;
            cnt_d   = sel_beats - CntW'(1);
          end
        end else if ((state_q == IDLE) && any_valid) begin
          state_d = HOLD;
          sel_d   = winner;
        end
      end
      BURST: begin
        if (handshake) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = IDLE;
            ptr_d   = next_idx(sel_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i < NumReq; i++) begin : g_size_chk
    a_legal_size : assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i[i] |-> (req_size_i[i*4 +: 4] <= 4'(MaxSize)))
      else $error("tl_burst_rr_arbiter: requester %0d size exceeds MaxSize", i);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tl_burst_rr_arbiter.sv
// ============================================================================
// tb_tl_burst_rr_arbiter : directed bench for the burst-aware RR arbiter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_tl_burst_rr_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [7:0]   req_size;
  logic [1:0]   req_has_data;
  logic [255:0] req_payload;
  logic         dev_valid;
  logic         dev_ready;
  logic [127:0] dev_payload;
  logic [0:0]   dev_idx;
  logic         dev_last;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  tl_burst_rr_arbiter #(
    .NumReq(2), .DataWidth(64), .PayloadWidth(128), .MaxSize(6)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_size_i    (req_size),
    .req_has_data_i(req_has_data),
    .req_payload_i (req_payload),
    .dev_valid_o   (dev_valid),
    .dev_ready_i   (dev_ready),
    .dev_payload_o (dev_payload),
    .dev_idx_o     (dev_idx),
    .dev_last_o    (dev_last)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pl(input int r, input int b);
    pl = {8'(r + 1), 88'h0, 32'(b)};
  endfunction

  task automatic set_req(input int r, input logic v, input logic [3:0] sz,
                         input logic hd, input int b);
    req_valid[r]               = v;
    req_size[r*4 +: 4]         = sz;
    req_has_data[r]            = hd;
    req_payload[r*128 +: 128]  = pl(r, b);
  endtask

  // Check one granted beat: index, per-requester ready, last flag and payload.
  task automatic chk_beat(input string tag, input logic idx, input logic [1:0] rdy,
                          input logic last, input int b);
    chk({tag, "_idx"},  128'(dev_idx),   128'(idx));
    chk({tag, "_rdy"},  128'(req_ready), 128'(rdy));
    chk({tag, "_last"}, 128'(dev_last),  128'(last));
    chk({tag, "_pl"},   dev_payload,     pl(idx, b));
  endtask

  initial begin
    int  done;
    logic exp_last;

    rst_ni       = 1'b0;
    req_valid    = '0;
    req_size     = '0;
    req_has_data = '0;
    req_payload  = '0;
    dev_ready    = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", 128'(dev_valid), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_idx",   128'(dev_idx),   128'(0));
    chk("rst_last",  128'(dev_last),  128'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: alternating single-beat Gets
    dev_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, 4'd3, 1'b0, c);
      set_req(1, 1'b1, 4'd3, 1'b0, c);
      #1;
      chk_beat("t1", 1'(c % 2), (c % 2) ? 2'b10 : 2'b01, 1'b1, c);
      @(negedge clk_i);
    end

    // 2: req0 8-beat PutFull locks out req1 Get
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 4'd6, 1'b1, c);
      set_req(1, 1'b1, 4'd3, 1'b0, 100);
      #1;
      chk_beat("t2_burst", 1'b0, 2'b01, (c == 7), c);
      @(negedge clk_i);
    end
    set_req(0, 1'b0, 4'd3, 1'b0, 0);
    #1;
    chk_beat("t2_after", 1'b1, 2'b10, 1'b1, 100);
    @(negedge clk_i);
    set_req(1, 1'b0, 4'd3, 1'b0, 0);

    // 3: HOLD keeps req1 selected while req0 joins
    dev_ready = 1'b0;
    set_req(1, 1'b1, 4'd3, 1'b0, 7);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 1'b1, 4'd3, 1'b0, 8);
      #1;
      chk("t3_hold_idx", 128'(dev_idx),   128'(1));
      chk("t3_hold_rdy", 128'(req_ready), 128'(0));
      chk("t3_hold_vld", 128'(dev_valid), 128'(1));
      @(negedge clk_i);
    end
    dev_ready = 1'b1;
    #1;
    chk_beat("t3_acc1", 1'b1, 2'b10, 1'b1, 7);
    @(negedge clk_i);
    set_req(1, 1'b0, 4'd3, 1'b0, 0);
    #1;
    chk_beat("t3_acc0", 1'b0, 2'b01, 1'b1, 8);
    @(negedge clk_i);
    set_req(0, 1'b0, 4'd3, 1'b0, 0);

    // 4: req1 burst with dev_ready toggling 1010...
    for (int c = 0; c < 15; c++) begin
      dev_ready = (c % 2 == 0);
      done      = (c + 1) / 2;
      exp_last  = (8 - done == 1);
      set_req(1, 1'b1, 4'd6, 1'b1, done);
      set_req(0, 1'b1, 4'd3, 1'b0, 50);
      #1;
      chk_beat("t4_burst", 1'b1, dev_ready ? 2'b10 : 2'b00, exp_last, done);
      @(negedge clk_i);
    end
    dev_ready = 1'b1;
    set_req(1, 1'b0, 4'd3, 1'b0, 0);
    #1;
    chk_beat("t4_after", 1'b0, 2'b01, 1'b1, 50);
    @(negedge clk_i);
    set_req(0, 1'b0, 4'd3, 1'b0, 0);

    // 5: reset at beat 3 of a 4-beat req1 burst
    for (int c = 0; c < 2; c++) begin
      set_req(1, 1'b1, 4'd5, 1'b1, c);
      set_req(0, 1'b1, 4'd3, 1'b0, 60);
      #1;
      chk_beat("t5_burst", 1'b1, 2'b10, 1'b0, c);
      @(negedge clk_i);
    end
    set_req(1, 1'b1, 4'd5, 1'b1, 2);
    #1;
    chk("t5_pre_idx", 128'(dev_idx), 128'(1));
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_idx",  128'(dev_idx),   128'(0));
    chk("t5_rst_vld",  128'(dev_valid), 128'(1));
    chk("t5_rst_last", 128'(dev_last),  128'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk_beat("t5_post", 1'b0, 2'b01, 1'b1, 60);
    @(negedge clk_i);
    set_req(0, 1'b0, 4'd3, 1'b0, 0);
    set_req(1, 1'b0, 4'd3, 1'b0, 0);
    @(negedge clk_i);

    // 6: has_data=0 at size 6 is a single beat and releases the pointer
    set_req(1, 1'b1, 4'd6, 1'b0, 70);
    set_req(0, 1'b1, 4'd3, 1'b0, 71);
    #1;
    chk_beat("t6_get1", 1'b1, 2'b10, 1'b1, 70);
    @(negedge clk_i);
    #1;
    chk_beat("t6_get0", 1'b0, 2'b01, 1'b1, 71);
    @(negedge clk_i);
    #1;
    chk_beat("t6_get1b", 1'b1, 2'b10, 1'b1, 70);
    @(negedge clk_i);
    set_req(0, 1'b0, 4'd3, 1'b0, 0);
    set_req(1, 1'b0, 4'd3, 1'b0, 0);
    #1;
    chk("t6_idle_vld", 128'(dev_valid), 128'(0));
    chk("t6_idle_rdy", 128'(req_ready), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
